// File: rtl/spw_pkg.sv
// Shared types and defaults for the SpaceWire link-interface state machine.
package spw_pkg;

    typedef enum logic [2:0] {
        ST_ERROR_RESET = 3'd0,
        ST_ERROR_WAIT  = 3'd1,
        ST_READY       = 3'd2,
        ST_STARTED     = 3'd3,
        ST_CONNECTING  = 3'd4,
        ST_RUN         = 3'd5
    } spw_link_state_t;

    localparam int unsigned T_6US4_DEF  = 64;
    localparam int unsigned T_12US8_DEF = 128;
    localparam int unsigned T_DISC_DEF  = 9;
    localparam int unsigned TIMER_W_DEF = 16;

    typedef struct packed {
        logic rx_resetn;
        logic enable_tx;
        logic send_null;
        logic send_fct;
        logic enable_data;
    } spw_link_ctl_t;

    // Receiver/transmitter controls implied by a link state.
    function automatic spw_link_ctl_t decode_ctl(input spw_link_state_t st);
        spw_link_ctl_t c;
        c             = '0;
        c.rx_resetn   = (st != ST_ERROR_RESET);
        c.enable_tx   = (st == ST_STARTED) || (st == ST_CONNECTING) || (st == ST_RUN);
        c.send_null   = c.enable_tx;
        c.send_fct    = (st == ST_CONNECTING) || (st == ST_RUN);
        c.enable_data = (st == ST_RUN);
        return c;
    endfunction

endpackage

// File: rtl/spw_link_timer.sv
// Loadable down-counter for the link state dwell times.
// expired is registered and is high during the last cycle of the loaded dwell.
module spw_link_timer
    import spw_pkg::*;
#(
    parameter int unsigned TIMER_W = TIMER_W_DEF,
    parameter int unsigned RST_VAL = T_6US4_DEF
) (
    input  logic               pclk,
    input  logic               resetn,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expired
);

    logic [TIMER_W-1:0] cnt;
    logic [TIMER_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = load_val;
        end else if (cnt != '0) begin
            cnt_next = cnt - TIMER_W'(1);
        end
    end

    // A count of one after this edge means the dwell ends on the next edge.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= TIMER_W'(RST_VAL);
            expired <= (RST_VAL == 32'd1);
        end else begin
            cnt     <= cnt_next;
            expired <= (cnt_next == TIMER_W'(1));
        end
    end

endmodule

// File: rtl/spw_link_fsm.sv
// SpaceWire link-interface state machine: sequences RX reset and TX enables,
// and tears the link down on receiver, credit or disconnect errors.
module spw_link_fsm
    import spw_pkg::*;
#(
    parameter int unsigned T_6US4  = T_6US4_DEF,
    parameter int unsigned T_12US8 = T_12US8_DEF,
    parameter int unsigned T_DISC  = T_DISC_DEF,
    parameter int unsigned TIMER_W = TIMER_W_DEF
) (
    input  logic       pclk,
    input  logic       resetn,
    input  logic       link_start,
    input  logic       auto_start,
    input  logic       link_disable,
    input  logic       rx_got_bit,
    input  logic       rx_got_null,
    input  logic       rx_got_fct,
    input  logic       rx_got_nchar,
    input  logic       rx_got_time_code,
    input  logic       rx_error,
    input  logic       credit_error,
    output logic       rx_resetn_out,
    output logic       enable_tx,
    output logic       send_null_tx,
    output logic       send_fct_tx,
    output logic       enable_data_tx,
    output logic [2:0] fsm_state,
    output logic       link_error
);

    spw_link_state_t state;
    spw_link_state_t state_next;

    logic null_q;
    logic fct_q;
    logic nchar_q;
    logic time_q;
    logic err_q;
    logic bit_q;

    logic got_null;
    logic got_fct;
    logic got_nchar;
    logic got_time;
    logic err_par;
    logic bit_chg;

    logic               disc_armed;
    logic [TIMER_W-1:0] disc_cnt;
    logic               disc_hit;
    logic               err_disc;
    logic               null_seen;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmo;

    logic err_line;
    logic err_early;
    logic link_en;

    spw_link_ctl_t ctl_q;
    spw_link_ctl_t ctl_d;
    logic          link_error_q;
    logic          link_error_d;

    // Previous samples for rising-edge / change detection.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            null_q  <= 1'b0;
            fct_q   <= 1'b0;
            nchar_q <= 1'b0;
            time_q  <= 1'b0;
            err_q   <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            null_q  <= rx_got_null;
            fct_q   <= rx_got_fct;
            nchar_q <= rx_got_nchar;
            time_q  <= rx_got_time_code;
            err_q   <= rx_error;
            bit_q   <= rx_got_bit;
        end
    end

    assign got_null  = rx_got_null      & ~null_q;
    assign got_fct   = rx_got_fct       & ~fct_q;
    assign got_nchar = rx_got_nchar     & ~nchar_q;
    assign got_time  = rx_got_time_code & ~time_q;
    assign err_par   = rx_error         & ~err_q;
    assign bit_chg   = rx_got_bit       ^ bit_q;

    // Disconnect detector: armed by the first line transition after RX reset lifts.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            disc_armed <= 1'b0;
            disc_cnt   <= '0;
        end else if (state == ST_ERROR_RESET) begin
            disc_armed <= 1'b0;
            disc_cnt   <= '0;
        end else if (bit_chg) begin
            disc_armed <= 1'b1;
            disc_cnt   <= '0;
        end else if (disc_armed && !disc_hit) begin
            disc_cnt   <= disc_cnt + TIMER_W'(1);
        end
    end

    assign disc_hit = (disc_cnt == TIMER_W'(T_DISC));
    assign err_disc = disc_armed & disc_hit;

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            null_seen <= 1'b0;
        end else if (state == ST_ERROR_RESET) begin
            null_seen <= 1'b0;
        end else if (got_null) begin
            null_seen <= 1'b1;
        end
    end

    // Reload the dwell timer on every state entry.
    assign tmr_load = (state_next != state);
    assign tmr_val  = (state_next == ST_ERROR_RESET) ? TIMER_W'(T_6US4) : TIMER_W'(T_12US8);

    spw_link_timer #(
        .TIMER_W (TIMER_W),
        .RST_VAL (T_6US4)
    ) u_state_timer (
        .pclk     (pclk),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmo)
    );

    assign err_line  = err_disc | err_par;
    assign err_early = err_line | got_fct | got_nchar | got_time;
    assign link_en   = ~link_disable & (link_start | (auto_start & null_seen));

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_ERROR_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Per-state priority: error, then progress event, then timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_ERROR_RESET: begin
                if (tmo) state_next = ST_ERROR_WAIT;
            end
            ST_ERROR_WAIT: begin
                if (err_early)  state_next = ST_ERROR_RESET;
                else if (tmo)   state_next = ST_READY;
            end
            ST_READY: begin
                if (err_early)    state_next = ST_ERROR_RESET;
                else if (link_en) state_next = ST_STARTED;
            end
            ST_STARTED: begin
                if (err_early)                  state_next = ST_ERROR_RESET;
                else if (got_null || null_seen) state_next = ST_CONNECTING;
                else if (tmo)                   state_next = ST_ERROR_RESET;
            end
            ST_CONNECTING: begin
                if (err_line || got_nchar || got_time) state_next = ST_ERROR_RESET;
                else if (got_fct)                      state_next = ST_RUN;
                else if (tmo)                          state_next = ST_ERROR_RESET;
            end
            ST_RUN: begin
                if (err_line || credit_error || link_disable) state_next = ST_ERROR_RESET;
            end
            default: state_next = ST_ERROR_RESET;
        endcase
    end

    // Outputs follow the next state; a host disable out of RUN is not a fault.
    always_comb begin
        ctl_d        = decode_ctl(state_next);
        link_error_d = 1'b0;
        if (state_next == ST_ERROR_RESET) begin
            case (state)
                ST_ERROR_WAIT, ST_READY, ST_STARTED, ST_CONNECTING: link_error_d = 1'b1;
                ST_RUN:  link_error_d = err_line | credit_error;
                default: link_error_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            ctl_q        <= '0;
            link_error_q <= 1'b0;
        end else begin
            ctl_q        <= ctl_d;
            link_error_q <= link_error_d;
        end
    end

    assign rx_resetn_out  = ctl_q.rx_resetn;
    assign enable_tx      = ctl_q.enable_tx;
    assign send_null_tx   = ctl_q.send_null;
    assign send_fct_tx    = ctl_q.send_fct;
    assign enable_data_tx = ctl_q.enable_data;
    assign fsm_state      = state;
    assign link_error     = link_error_q;

endmodule

// File: tb/tb_spw_link_fsm.sv
// Bench for spw_link_fsm: directed link scenarios followed by random traffic,
// all checked every cycle against a rule-level model of the link sequence.
module tb_spw_link_fsm;

    localparam int T_6US4  = 64;
    localparam int T_12US8 = 128;
    localparam int T_DISC  = 9;
    localparam int TIMER_W = 16;

    logic       pclk             = 1'b0;
    logic       resetn           = 1'b0;
    logic       link_start       = 1'b0;
    logic       auto_start       = 1'b0;
    logic       link_disable     = 1'b0;
    logic       rx_got_bit       = 1'b0;
    logic       rx_got_null      = 1'b0;
    logic       rx_got_fct       = 1'b0;
    logic       rx_got_nchar     = 1'b0;
    logic       rx_got_time_code = 1'b0;
    logic       rx_error         = 1'b0;
    logic       credit_error     = 1'b0;
    logic       rx_resetn_out;
    logic       enable_tx;
    logic       send_null_tx;
    logic       send_fct_tx;
    logic       enable_data_tx;
    logic [2:0] fsm_state;
    logic       link_error;

    spw_link_fsm #(
        .T_6US4  (T_6US4),
        .T_12US8 (T_12US8),
        .T_DISC  (T_DISC),
        .TIMER_W (TIMER_W)
    ) dut (
        .pclk             (pclk),
        .resetn           (resetn),
        .link_start       (link_start),
        .auto_start       (auto_start),
        .link_disable     (link_disable),
        .rx_got_bit       (rx_got_bit),
        .rx_got_null      (rx_got_null),
        .rx_got_fct       (rx_got_fct),
        .rx_got_nchar     (rx_got_nchar),
        .rx_got_time_code (rx_got_time_code),
        .rx_error         (rx_error),
        .credit_error     (credit_error),
        .rx_resetn_out    (rx_resetn_out),
        .enable_tx        (enable_tx),
        .send_null_tx     (send_null_tx),
        .send_fct_tx      (send_fct_tx),
        .enable_data_tx   (enable_data_tx),
        .fsm_state        (fsm_state),
        .link_error       (link_error)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    bit bit_run = 1'b0;

    // Model: link state by spec code, cycles spent in it, line quiet time.
    int m_state;
    int m_age;
    int m_quiet;
    bit m_armed;
    bit m_null_seen;
    bit m_lerr;
    bit p_null, p_fct, p_nchar, p_time, p_err, p_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_age = 0; m_quiet = 0;
        m_armed = 0; m_null_seen = 0; m_lerr = 0;
        p_null = 0; p_fct = 0; p_nchar = 0; p_time = 0; p_err = 0; p_bit = 0;
    endtask

    // One clock edge of the link rules; nxt = -1 marks a fault teardown.
    task automatic model_edge();
        bit e_null, e_fct, e_nchar, e_time, e_par, chg, fault, lnk, tmo_long;
        int nxt;
        e_null   = rx_got_null && !p_null;
        e_fct    = rx_got_fct && !p_fct;
        e_nchar  = rx_got_nchar && !p_nchar;
        e_time   = rx_got_time_code && !p_time;
        e_par    = rx_error && !p_err;
        chg      = (rx_got_bit != p_bit);
        fault    = (m_armed && (m_quiet >= T_DISC)) || e_par;
        tmo_long = (m_age == T_12US8 - 1);
        lnk      = !link_disable && (link_start || (auto_start && m_null_seen));
        nxt      = m_state;
        case (m_state)
            0: if (m_age == T_6US4 - 1) nxt = 1;
            1, 2, 3: begin
                if (fault || e_fct || e_nchar || e_time)         nxt = -1;
                else if (m_state == 1 && tmo_long)               nxt = 2;
                else if (m_state == 2 && lnk)                    nxt = 3;
                else if (m_state == 3 && (e_null || m_null_seen)) nxt = 4;
                else if (m_state == 3 && tmo_long)               nxt = -1;
            end
            4: begin
                if (fault || e_nchar || e_time) nxt = -1;
                else if (e_fct)                 nxt = 5;
                else if (tmo_long)              nxt = -1;
            end
            5: begin
                if (fault || credit_error) nxt = -1;
                else if (link_disable)     nxt = 0;
            end
            default: nxt = -1;
        endcase
        m_lerr = (nxt == -1);
        if (nxt == -1) nxt = 0;
        if (m_state == 0) begin
            m_armed = 0; m_quiet = 0; m_null_seen = 0;
        end else begin
            if (chg) begin
                m_armed = 1; m_quiet = 0;
            end else if (m_armed) begin
                m_quiet++;
            end
            if (e_null) m_null_seen = 1;
        end
        m_age   = (nxt != m_state) ? 0 : m_age + 1;
        m_state = nxt;
        p_null = rx_got_null; p_fct = rx_got_fct; p_nchar = rx_got_nchar;
        p_time = rx_got_time_code; p_err = rx_error; p_bit = rx_got_bit;
    endtask

    function automatic logic [31:0] exp_vec();
        logic [2:0] s;
        logic rx_r, en, fct, data;
        s    = 3'(m_state);
        rx_r = (m_state != 0);
        en   = (m_state >= 3);
        fct  = (m_state >= 4);
        data = (m_state == 5);
        return {23'd0, s, rx_r, en, en, fct, data, m_lerr};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {23'd0, fsm_state, rx_resetn_out, enable_tx, send_null_tx,
                send_fct_tx, enable_data_tx, link_error};
    endfunction

    task automatic tick();
        @(posedge pclk);
        model_edge();
        @(negedge pclk);
        check("cycle", obs_vec(), exp_vec());
        if (bit_run) rx_got_bit = ~rx_got_bit;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        model_reset();
        #1;
        check("reset_values", obs_vec(), 32'd0);
        repeat (n) @(posedge pclk);
        @(negedge pclk);
        resetn = 1'b1;
    endtask

    initial begin
        int pulses;
        int n;
        int freeze;

        // Reset release with a silent line.
        do_reset(3);
        ticks(63);
        check("er_dwell_state", 32'(fsm_state), 32'd0);
        check("er_dwell_rxrst", 32'(rx_resetn_out), 32'd0);
        tick();
        check("ew_at_64", 32'(fsm_state), 32'd1);
        check("rxrst_rise_64", 32'(rx_resetn_out), 32'd1);
        ticks(127);
        check("ew_dwell", 32'(fsm_state), 32'd1);
        tick();
        check("ready_at_192", 32'(fsm_state), 32'd2);

        // Host start, NULL then FCT bring the link to RUN.
        bit_run = 1'b1;
        link_start = 1'b1;
        tick();
        check("started", 32'(fsm_state), 32'd3);
        ticks(19);
        rx_got_null = 1'b1;
        tick();
        check("connecting", 32'(fsm_state), 32'd4);
        check("fct_enabled", 32'(send_fct_tx), 32'd1);
        ticks(19);
        rx_got_fct = 1'b1;
        tick();
        check("run", 32'(fsm_state), 32'd5);
        check("data_enabled", 32'(enable_data_tx), 32'd1);

        // Frozen line in RUN: disconnect teardown with a single error pulse.
        bit_run = 1'b0;
        pulses = 0;
        n = 0;
        while (fsm_state !== 3'd0 && n < 30) begin
            tick();
            n++;
            pulses += 32'(link_error);
        end
        check("disc_latency", 32'(n), 32'd11);
        tick();
        pulses += 32'(link_error);
        check("disc_pulse_once", 32'(pulses), 32'd1);
        rx_got_null = 1'b0;
        rx_got_fct  = 1'b0;
        bit_run = 1'b1;

        // STARTED without NULL times out.
        ticks(191);
        check("ready_again", 32'(fsm_state), 32'd2);
        tick();
        check("started_again", 32'(fsm_state), 32'd3);
        ticks(127);
        check("started_dwell", 32'(fsm_state), 32'd3);
        tick();
        check("started_tmo", 32'(fsm_state), 32'd0);
        check("started_tmo_err", 32'(link_error), 32'd1);
        link_start = 1'b0;
        ticks(63);
        check("restart_rxrst_low", 32'(rx_resetn_out), 32'd0);
        tick();
        check("restart_rxrst_high", 32'(rx_resetn_out), 32'd1);

        // FCT while in ERROR_WAIT is an error; NULL is not.
        ticks(99);
        rx_got_fct = 1'b1;
        tick();
        check("ew_fct_state", 32'(fsm_state), 32'd0);
        check("ew_fct_err", 32'(link_error), 32'd1);
        rx_got_fct = 1'b0;
        ticks(64);
        check("ew_reentry", 32'(fsm_state), 32'd1);
        ticks(99);
        rx_got_null = 1'b1;
        tick();
        check("ew_null_state", 32'(fsm_state), 32'd1);
        check("ew_null_noerr", 32'(link_error), 32'd0);
        ticks(27);
        check("ew_tail", 32'(fsm_state), 32'd1);
        tick();
        check("ready_null_seen", 32'(fsm_state), 32'd2);
        auto_start = 1'b1;
        tick();
        check("auto_started", 32'(fsm_state), 32'd3);
        tick();
        check("auto_connecting", 32'(fsm_state), 32'd4);

        // FCT on the CONNECTING expiry cycle wins over the timeout.
        ticks(127);
        check("conn_dwell", 32'(fsm_state), 32'd4);
        rx_got_fct = 1'b1;
        tick();
        check("fct_on_expiry", 32'(fsm_state), 32'd5);

        // Host disable out of RUN is silent and parks in READY.
        link_disable = 1'b1;
        rx_got_null = 1'b0;
        rx_got_fct = 1'b0;
        tick();
        check("disable_state", 32'(fsm_state), 32'd0);
        check("disable_noerr", 32'(link_error), 32'd0);
        ticks(192);
        check("parked_ready", 32'(fsm_state), 32'd2);
        ticks(50);
        check("still_parked", 32'(fsm_state), 32'd2);

        // Parity error together with FCT in CONNECTING.
        link_disable = 1'b0;
        auto_start = 1'b0;
        link_start = 1'b1;
        tick();
        check("par_started", 32'(fsm_state), 32'd3);
        rx_got_null = 1'b1;
        tick();
        check("par_connecting", 32'(fsm_state), 32'd4);
        rx_error = 1'b1;
        rx_got_fct = 1'b1;
        tick();
        check("par_over_fct", 32'(fsm_state), 32'd0);
        check("par_err", 32'(link_error), 32'd1);
        rx_error = 1'b0;
        rx_got_fct = 1'b0;
        rx_got_null = 1'b0;

        // Disable ignored in CONNECTING; credit error tears down RUN.
        ticks(192);
        check("cr_ready", 32'(fsm_state), 32'd2);
        tick();
        rx_got_null = 1'b1;
        tick();
        check("cr_connecting", 32'(fsm_state), 32'd4);
        link_disable = 1'b1;
        tick();
        check("disable_ignored", 32'(fsm_state), 32'd4);
        link_disable = 1'b0;
        rx_got_fct = 1'b1;
        tick();
        check("cr_run", 32'(fsm_state), 32'd5);
        credit_error = 1'b1;
        tick();
        credit_error = 1'b0;
        check("credit_state", 32'(fsm_state), 32'd0);
        check("credit_err", 32'(link_error), 32'd1);

        // Mid-operation reset needs the full sequence again.
        ticks(100);
        do_reset(2);
        ticks(63);
        check("rst_er_dwell", 32'(fsm_state), 32'd0);
        tick();
        check("rst_ew", 32'(fsm_state), 32'd1);

        // Random traffic against the model.
        bit_run = 1'b0;
        freeze = 0;
        for (int c = 0; c < 4000; c++) begin
            if (freeze > 0) freeze--;
            else if ($urandom_range(0, 399) == 0) freeze = 12;
            else if ($urandom_range(0, 9) != 0) rx_got_bit = ~rx_got_bit;
            if ($urandom_range(0, 49) == 0)  rx_got_null = ~rx_got_null;
            if ($urandom_range(0, 199) == 0) rx_got_fct = ~rx_got_fct;
            if ($urandom_range(0, 799) == 0) rx_got_nchar = ~rx_got_nchar;
            if ($urandom_range(0, 799) == 0) rx_got_time_code = ~rx_got_time_code;
            if ($urandom_range(0, 599) == 0) rx_error = ~rx_error;
            if ($urandom_range(0, 99) == 0)  link_start = ~link_start;
            if ($urandom_range(0, 99) == 0)  auto_start = ~auto_start;
            if ($urandom_range(0, 299) == 0) link_disable = ~link_disable;
            credit_error = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 999) == 0) do_reset(2);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
